// File: rtl/msg_printer.sv
// msg_printer: on a UART command byte, streams a zero-terminated message from an
// external ROM slot to the UART transmitter, with one pending command and abort.
module msg_printer #(
    parameter int         NUM_MSG    = 4,
    parameter int         SLOT_LEN   = 16,
    parameter logic [7:0] CMD_BASE   = 8'h61,
    parameter logic [7:0] ABORT_CHAR = 8'h1B,
    localparam int        ROM_AW     = ($clog2(NUM_MSG * SLOT_LEN) < 1) ? 1 : $clog2(NUM_MSG * SLOT_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              new_rx_data,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              busy,
    output logic              done,
    output logic [3:0]        msg_id
);

    localparam int                IDX_W    = $clog2(SLOT_LEN);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(SLOT_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ZERO = IDX_W'(0);
    localparam logic [ROM_AW-1:0] ADDR_ONE = ROM_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CHECK = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              new_tx_data_q, new_tx_data_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [3:0]        msg_id_q, msg_id_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pend_valid_q, pend_valid_d;
    logic [3:0]        pend_id_q, pend_id_d;

    logic [7:0]        cmd_off_s;
    logic              abort_s;
    logic              cmd_valid_s;
    logic [3:0]        cmd_id_s;
    logic              launch_s;
    logic [3:0]        launch_id_s;

    // Command decode; the upper bound is compared in 32 bits so CMD_BASE+NUM_MSG cannot overflow
    always_comb begin
        cmd_off_s   = rx_data - CMD_BASE;
        abort_s     = new_rx_data && (rx_data == ABORT_CHAR);
        cmd_valid_s = new_rx_data && !abort_s && (rx_data >= CMD_BASE)
                      && ({24'd0, cmd_off_s} < 32'(NUM_MSG));
        cmd_id_s    = cmd_off_s[3:0];
    end

    // Next-state, pending-entry and output computation
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        new_tx_data_d = 1'b0;
        done_d        = 1'b0;
        busy_d        = 1'b0;
        rom_addr_d    = rom_addr_q;
        msg_id_d      = msg_id_q;
        idx_d         = idx_q;
        pend_valid_d  = pend_valid_q;
        pend_id_d     = pend_id_q;
        launch_s      = 1'b0;
        launch_id_s   = pend_id_q;

        if (cmd_valid_s && (state_q != S_IDLE)) begin
            pend_valid_d = 1'b1;
            pend_id_d    = cmd_id_s;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (abort_s) begin
                    pend_valid_d = 1'b0;
                end else if (pend_valid_q) begin
                    // Pending entry goes first; a same-cycle command takes its place
                    launch_s     = 1'b1;
                    launch_id_s  = pend_id_q;
                    pend_valid_d = cmd_valid_s;
                    pend_id_d    = cmd_valid_s ? cmd_id_s : pend_id_q;
                end else if (cmd_valid_s) begin
                    launch_s    = 1'b1;
                    launch_id_s = cmd_id_s;
                end else begin
                    launch_s = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (rom_data == 8'h00) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tx_data_d = rom_data;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    new_tx_data_d = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d      = idx_q + IDX_ONE;
                        rom_addr_d = rom_addr_q + ADDR_ONE;
                        state_d    = S_FETCH;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (launch_s) begin
            msg_id_d   = launch_id_s;
            rom_addr_d = ROM_AW'({28'd0, launch_id_s} * 32'(SLOT_LEN));
            idx_d      = IDX_ZERO;
            state_d    = S_FETCH;
        end else begin
            msg_id_d = msg_id_q;
        end

        // Abort ends the message; a strobe already decided this cycle still goes out
        if (abort_s && (state_q != S_IDLE)) begin
            pend_valid_d = 1'b0;
            done_d       = 1'b1;
            state_d      = S_IDLE;
            busy_d       = 1'b0;
        end else begin
            busy_d = (state_d != S_IDLE);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tx_data_q     <= 8'h00;
            new_tx_data_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            rom_addr_q    <= {ROM_AW{1'b0}};
            msg_id_q      <= 4'd0;
            idx_q         <= IDX_ZERO;
            pend_valid_q  <= 1'b0;
            pend_id_q     <= 4'd0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            new_tx_data_q <= new_tx_data_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            rom_addr_q    <= rom_addr_d;
            msg_id_q      <= msg_id_d;
            idx_q         <= idx_d;
            pend_valid_q  <= pend_valid_d;
            pend_id_q     <= pend_id_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_data_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign rom_addr    = rom_addr_q;
    assign msg_id      = msg_id_q;

endmodule

// File: tb/tb_msg_printer.sv
// tb_msg_printer: directed and randomized checks of msg_printer against a
// message-level model (the byte stream each command must produce).
module tb_msg_printer;
    localparam int         NUM_MSG  = 4;
    localparam int         SLOT_LEN = 16;
    localparam int         ROM_AW   = 6;
    localparam logic [7:0] CMD_BASE = 8'h61;
    localparam logic [7:0] ESC      = 8'h1B;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              new_rx_data;
    logic              tx_busy;
    logic [7:0]        tx_data;
    logic              new_tx_data;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              busy;
    logic              done;
    logic [3:0]        msg_id;

    logic [7:0] rom_mem [0:NUM_MSG*SLOT_LEN-1];
    logic [7:0] exp_byte_q[$];
    int         exp_msg_q[$];
    logic [7:0] obs_byte_q[$];
    int         obs_msg_q[$];
    int strobe_cnt, done_cnt, done_with_strobe, min_addr, max_addr;
    int errors, checks, busy_len;

    msg_printer #(
        .NUM_MSG(NUM_MSG), .SLOT_LEN(SLOT_LEN), .CMD_BASE(CMD_BASE), .ABORT_CHAR(ESC)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_busy(tx_busy), .tx_data(tx_data), .new_tx_data(new_tx_data),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done), .msg_id(msg_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int obs_at(input int i);
        if (i < obs_byte_q.size()) return int'(obs_byte_q[i]);
        return -1;
    endfunction

    function automatic int obs_msg_at(input int i);
        if (i < obs_msg_q.size()) return obs_msg_q[i];
        return -1;
    endfunction

    function automatic int msg_len(input int m);
        for (int i = 0; i < SLOT_LEN; i++)
            if (rom_mem[m*SLOT_LEN+i] == 8'h00) return i;
        return SLOT_LEN;
    endfunction

    // Model: message m yields its bytes up to the first zero or the slot end
    task automatic expect_msg(input int m, input int max_bytes);
        for (int i = 0; i < SLOT_LEN && i < max_bytes; i++) begin
            if (rom_mem[m*SLOT_LEN+i] == 8'h00) break;
            exp_byte_q.push_back(rom_mem[m*SLOT_LEN+i]);
            exp_msg_q.push_back(m);
        end
    endtask

    task automatic set_str(input int slot, input string s);
        for (int i = 0; i < SLOT_LEN; i++) rom_mem[slot*SLOT_LEN+i] = 8'($urandom_range(1, 255));
        for (int i = 0; i < s.len(); i++) rom_mem[slot*SLOT_LEN+i] = s[i];
        if (s.len() < SLOT_LEN) rom_mem[slot*SLOT_LEN+s.len()] = 8'h00;
    endtask

    // Call just after a rising edge; the byte is sampled on the next one
    task automatic send_rx(input logic [7:0] b);
        #1;
        rx_data     = b;
        new_rx_data = 1'b1;
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
        rx_data     = 8'h00;
    endtask

    task automatic wait_strobes(input int target);
        int n = 0;
        @(posedge clk);
        while (strobe_cnt < target && n < 3000) begin @(posedge clk); n++; end
        if (strobe_cnt < target) begin
            checks++; errors++;
            $display("FAIL strobe_timeout: got %0d strobes, expected %0d", strobe_cnt, target);
        end
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        @(posedge clk);
        while (done_cnt < target && n < 3000) begin @(posedge clk); n++; end
        if (done_cnt < target) begin
            checks++; errors++;
            $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_cnt, target);
        end
    endtask

    task automatic clear_obs();
        obs_byte_q.delete();
        obs_msg_q.delete();
    endtask

    // Transmitter model: busy for busy_len cycles starting the cycle after a strobe
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (new_tx_data && busy_len > 0) begin
                @(posedge clk); #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Compare process: every strobe against the model, plus protocol rules
    initial begin
        logic prev_strobe;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (new_tx_data) begin
                    strobe_cnt++;
                    obs_byte_q.push_back(tx_data);
                    obs_msg_q.push_back(int'(msg_id));
                    chk("strobe_while_tx_busy", int'(tx_busy), 0);
                    chk("strobe_back_to_back", int'(prev_strobe), 0);
                    if (exp_byte_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_strobe: got byte 0x%0h, expected no strobe", tx_data);
                    end else begin
                        chk("tx_data", int'(tx_data), int'(exp_byte_q.pop_front()));
                        chk("msg_id_at_strobe", int'(msg_id), exp_msg_q.pop_front());
                    end
                    if (done) done_with_strobe++;
                end
                if (done) done_cnt++;
                if (busy) begin
                    chk("rom_addr_in_slot", int'(rom_addr) / SLOT_LEN, int'(msg_id));
                    if (int'(rom_addr) < min_addr) min_addr = int'(rom_addr);
                    if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
                end
                prev_strobe = new_tx_data;
            end else begin
                prev_strobe = 1'b0;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_data"}, int'(tx_data), 0);
        chk({tag, "_new_tx_data"}, int'(new_tx_data), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rom_addr"}, int'(rom_addr), 0);
        chk({tag, "_msg_id"}, int'(msg_id), 0);
    endtask

    initial begin
        int bs, bd, bw;
        rst = 1'b1; rx_data = 8'h00; new_rx_data = 1'b0; busy_len = 0;
        for (int i = 0; i < NUM_MSG*SLOT_LEN; i++) rom_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");

        // "hi" then terminator
        set_str(0, "hi");
        clear_obs(); bs = strobe_cnt; bd = done_cnt;
        expect_msg(0, SLOT_LEN);
        @(posedge clk); send_rx(CMD_BASE);
        wait_done(bd + 1);
        repeat (5) @(posedge clk);
        chk("hi_strobes", strobe_cnt - bs, 2);
        chk("hi_byte0", obs_at(0), 8'h68);
        chk("hi_byte1", obs_at(1), 8'h69);
        chk("hi_done", done_cnt - bd, 1);

        // Full slot without terminator
        for (int i = 0; i < SLOT_LEN; i++) rom_mem[SLOT_LEN+i] = 8'(8'h41 + i);
        busy_len = 3; min_addr = 9999; max_addr = -1;
        clear_obs(); bs = strobe_cnt; bd = done_cnt; bw = done_with_strobe;
        expect_msg(1, SLOT_LEN);
        @(posedge clk); send_rx(CMD_BASE + 8'd1);
        wait_done(bd + 1);
        repeat (5) @(posedge clk);
        chk("full_strobes", strobe_cnt - bs, 16);
        chk("full_done", done_cnt - bd, 1);
        chk("full_done_on_last", done_with_strobe - bw, 1);
        chk("full_min_addr", min_addr, 16);
        chk("full_max_addr", max_addr, 31);
        chk("full_last_byte", obs_at(15), 8'h50);

        // Slow transmitter
        set_str(2, "UART!");
        busy_len = 10;
        clear_obs(); bs = strobe_cnt; bd = done_cnt;
        expect_msg(2, SLOT_LEN);
        @(posedge clk); send_rx(CMD_BASE + 8'd2);
        wait_done(bd + 1);
        repeat (12) @(posedge clk);
        chk("slow_strobes", strobe_cnt - bs, 5);
        chk("slow_byte0", obs_at(0), 8'h55);
        chk("slow_byte4", obs_at(4), 8'h21);

        // Pending entry: last command wins
        busy_len = 0;
        set_str(0, "hi"); set_str(1, "xyz"); set_str(2, "QQ");
        clear_obs(); bs = strobe_cnt; bd = done_cnt;
        expect_msg(0, SLOT_LEN); expect_msg(1, SLOT_LEN);
        @(posedge clk); send_rx(CMD_BASE);
        wait_strobes(bs + 1);
        send_rx(CMD_BASE + 8'd2);
        send_rx(CMD_BASE + 8'd1);
        wait_done(bd + 2);
        repeat (10) @(posedge clk);
        chk("pend_strobes", strobe_cnt - bs, 5);
        chk("pend_done", done_cnt - bd, 2);
        chk("pend_msg1", obs_msg_at(1), 0);
        chk("pend_msg2", obs_msg_at(2), 1);
        chk("pend_byte4", obs_at(4), 8'h7A);

        // Abort after the 2nd byte of a 10-byte message
        set_str(3, "0123456789");
        clear_obs(); bs = strobe_cnt; bd = done_cnt;
        expect_msg(3, 2);
        @(posedge clk); send_rx(CMD_BASE + 8'd3);
        wait_strobes(bs + 2);
        send_rx(ESC);
        chk("abort_busy_low", int'(busy), 0);
        chk("abort_done", int'(done), 1);
        repeat (30) @(posedge clk);
        chk("abort_strobes", strobe_cnt - bs, 2);
        chk("abort_done_once", done_cnt - bd, 1);
        clear_obs(); bs = strobe_cnt;
        expect_msg(0, SLOT_LEN);
        @(posedge clk); send_rx(CMD_BASE);
        wait_done(bd + 2);
        repeat (5) @(posedge clk);
        chk("after_abort_strobes", strobe_cnt - bs, 2);
        chk("after_abort_byte1", obs_at(1), 8'h69);

        // Reset mid-message with a same-cycle command, then ignored bytes
        clear_obs(); bs = strobe_cnt; bd = done_cnt;
        expect_msg(3, SLOT_LEN);
        @(posedge clk); send_rx(CMD_BASE + 8'd3);
        wait_strobes(bs + 3);
        #1 rst = 1'b1; rx_data = CMD_BASE; new_rx_data = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; new_rx_data = 1'b0; rx_data = 8'h00;
        exp_byte_q.delete(); exp_msg_q.delete();
        chk_reset_outputs("midrst");
        @(posedge clk); send_rx(8'h7A);
        send_rx(8'h60);
        repeat (30) @(posedge clk);
        chk("midrst_strobes", strobe_cnt - bs, 3);
        chk("midrst_done", done_cnt - bd, 0);
        chk("midrst_busy", int'(busy), 0);

        // Randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            int m0, l0, n_extra, pend, exp_dones, r;
            bit do_abort;
            logic [7:0] xb [0:1];
            for (int s = 0; s < NUM_MSG; s++) begin
                int len = $urandom_range(0, SLOT_LEN);
                for (int i = 0; i < SLOT_LEN; i++)
                    rom_mem[s*SLOT_LEN+i] = (i < len) ? 8'($urandom_range(1, 255)) :
                                            (i == len) ? 8'h00 : 8'($urandom_range(0, 255));
            end
            busy_len = $urandom_range(0, 10);
            m0 = $urandom_range(0, NUM_MSG - 1);
            l0 = msg_len(m0);
            n_extra = $urandom_range(0, 2);
            if (n_extra > l0 - 1) n_extra = (l0 > 1) ? l0 - 1 : 0;
            do_abort = ($urandom_range(0, 3) == 0) && (l0 >= n_extra + 2);
            pend = -1;
            for (int j = 0; j < n_extra; j++) begin
                r = $urandom_range(0, 5);
                xb[j] = (r < 4) ? 8'(CMD_BASE + 8'(r)) : ((r == 4) ? 8'h7A : 8'h60);
                if (r < 4) pend = r;
            end
            exp_byte_q.delete(); exp_msg_q.delete();
            if (do_abort) begin
                expect_msg(m0, n_extra + 1);
                exp_dones = 1;
            end else begin
                expect_msg(m0, SLOT_LEN);
                if (pend >= 0) expect_msg(pend, SLOT_LEN);
                exp_dones = (pend >= 0) ? 2 : 1;
            end
            bs = strobe_cnt; bd = done_cnt;
            @(posedge clk); send_rx(8'(CMD_BASE + 8'(m0)));
            for (int j = 0; j < n_extra; j++) begin
                wait_strobes(bs + j + 1);
                send_rx(xb[j]);
            end
            if (do_abort) begin
                wait_strobes(bs + n_extra + 1);
                send_rx(ESC);
            end
            wait_done(bd + exp_dones);
            repeat (8) @(posedge clk);
            chk("ep_done_count", done_cnt - bd, exp_dones);
            chk("ep_missing_bytes", exp_byte_q.size(), 0);
            chk("ep_idle", int'(busy), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
